count2b: RTL and testbench
==========================

COUNT2B -- requirements
Module: count2b

Interface
REQ-001 The module SHALL have parameter WIDTH, default 2, giving the counter width in bits; all requirements below use the default.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous active-low reset, acting immediately on assertion (reset=0) without waiting for clk.
REQ-004 The module SHALL have port resetcount, input, 1 bit: synchronous active-high clear request, sampled at each rising clk edge.
REQ-005 The module SHALL have port stop, input, 1 bit: active-high hold request, sampled at each rising clk edge.
REQ-006 The module SHALL have port cycle, output, WIDTH bits: the current count value, driven directly from a register.
REQ-007 The module SHALL place clk, resetcount, stop and cycle in positions 1, 2, 3 and 4 of the port list, in that order, and reset last, so that the positional instantiation (clk, resetcount, stop, cycle) stays valid.

Function
REQ-008 The module SHALL hold one WIDTH-bit state register, cnt, and SHALL drive cycle from cnt.
REQ-009 On each rising clk edge with reset=1, the module SHALL update cnt by the first matching rule below, in priority order.
REQ-010 Rule 1: if stop=1, cnt SHALL keep its value (hold).
REQ-011 Rule 2: if stop=0 and resetcount=1, cnt SHALL become 0.
REQ-012 Rule 3: if stop=0 and resetcount=0, cnt SHALL become cnt+1 modulo 2^WIDTH, so 3 wraps to 0 with no flag.
REQ-013 stop SHALL take precedence over resetcount when both are 1 on the same edge; cycle SHALL hold its value (HALT behaviour).
REQ-014 Hold SHALL not be sticky inside the block: when stop returns to 0, counting or clearing SHALL resume on the next edge.
REQ-015 Latency SHALL be one clock: a change on resetcount or stop affects cycle only after the next rising edge, never combinationally.
REQ-016 resetcount and stop SHALL be usable when driven combinationally from cycle by the enclosing controller; cycle SHALL have no combinational path from any input.
REQ-017 The block SHALL need no handshake; every value of cycle from 0 to 3 SHALL be reachable.

Reset
REQ-018 While reset=0, cnt and cycle SHALL be 0 and held there, regardless of clk, resetcount and stop.
REQ-019 On deassertion of reset, the first rising edge SHALL apply REQ-009..012 starting from 0; with stop=0 and resetcount=0, cycle SHALL become 1.
REQ-020 Asserting reset mid-count SHALL force cycle to 0 asynchronously, within the same simulation time step.
REQ-021 The block SHALL need no initial blocks; reset alone SHALL establish the defined state.

Verification
REQ-022 Free run: reset pulse, then stop=0 and resetcount=0 for 6 edges -> cycle 1,2,3,0,1,2.
REQ-023 Sync clear: at cycle=1, drive resetcount=1 for one edge -> cycle=0, then 1 on the following edge; repeating this gives the sequence 0,1,0,1.
REQ-024 Hold: at cycle=2, drive stop=1 for 3 edges -> cycle stays 2; release stop -> cycle=3 on the next edge.
REQ-025 Priority: at cycle=1, drive stop=1 and resetcount=1 together -> cycle stays 1 for every edge while both are high.
REQ-026 Async reset: at cycle=3, drive reset=0 between edges -> cycle=0 immediately; with reset=0 held across 2 edges -> cycle stays 0.

Source files
------------

// File: rtl/count2b.sv
// count2b: WIDTH-bit wrapping cycle counter with synchronous clear and hold.
// Rev 1.0
`default_nettype none

module count2b #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             resetcount,
  input  logic             stop,
  output logic [WIDTH-1:0] cycle,
  input  logic             reset
);

  localparam logic [WIDTH-1:0] c_ZERO = '0;
  localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;

  // Hold outranks clear; clear outranks increment. Wrap is silent.
  always_comb begin
    w_cnt_nxt = r_cnt + c_ONE;
    if (stop) begin
      w_cnt_nxt = r_cnt;
    end else if (resetcount) begin
      w_cnt_nxt = c_ZERO;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= c_ZERO;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign cycle = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_count2b.sv
// tb_count2b: directed self-checking bench for count2b.
// Rev 1.0
`default_nettype none

module tb_count2b;

  logic       clk;
  logic       resetcount;
  logic       stop;
  logic [1:0] cycle;
  logic       reset;

  int vectors;
  int miscompares;

  count2b #(.WIDTH(2)) dut (
    .clk        (clk),
    .resetcount (resetcount),
    .stop       (stop),
    .cycle      (cycle),
    .reset      (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (cycle !== 2'd0) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: got %0d want 0", i, cycle);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_free_run();
    logic [1:0] exp_seq [6];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    stop = 1'b0;
    resetcount = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (cycle !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL free_run[%0d]: got %0d want %0d", i, cycle, exp_seq[i]);
      end
    end
  endtask

  task automatic test_sync_clear();
    logic [1:0] exp_seq [4];
    exp_seq = '{2'd0, 2'd1, 2'd0, 2'd1};
    // From 2: clear, then count once to land on 1.
    resetcount = 1'b1;
    tick();
    resetcount = 1'b0;
    tick();
    vectors++;
    if (cycle !== 2'd1) begin
      miscompares++;
      $display("FAIL sync_clear_setup: got %0d want 1", cycle);
    end
    for (int i = 0; i < 4; i++) begin
      resetcount = (i % 2 == 0);
      tick();
      vectors++;
      if (cycle !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL sync_clear[%0d]: got %0d want %0d", i, cycle, exp_seq[i]);
      end
    end
    resetcount = 1'b0;
  endtask

  task automatic test_hold();
    tick();
    vectors++;
    if (cycle !== 2'd2) begin
      miscompares++;
      $display("FAIL hold_setup: got %0d want 2", cycle);
    end
    stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (cycle !== 2'd2) begin
        miscompares++;
        $display("FAIL hold[%0d]: got %0d want 2", i, cycle);
      end
    end
    stop = 1'b0;
    tick();
    vectors++;
    if (cycle !== 2'd3) begin
      miscompares++;
      $display("FAIL hold_release: got %0d want 3", cycle);
    end
  endtask

  task automatic test_priority();
    resetcount = 1'b1;
    tick();
    resetcount = 1'b0;
    tick();
    vectors++;
    if (cycle !== 2'd1) begin
      miscompares++;
      $display("FAIL prio_setup: got %0d want 1", cycle);
    end
    stop = 1'b1;
    resetcount = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (cycle !== 2'd1) begin
        miscompares++;
        $display("FAIL prio_hold[%0d]: got %0d want 1", i, cycle);
      end
    end
    // Stop drops while clear stays high: clear must take effect.
    stop = 1'b0;
    tick();
    vectors++;
    if (cycle !== 2'd0) begin
      miscompares++;
      $display("FAIL prio_release_clear: got %0d want 0", cycle);
    end
    resetcount = 1'b0;
    tick();
    vectors++;
    if (cycle !== 2'd1) begin
      miscompares++;
      $display("FAIL prio_resume: got %0d want 1", cycle);
    end
  endtask

  task automatic test_async_reset();
    tick();
    tick();
    vectors++;
    if (cycle !== 2'd3) begin
      miscompares++;
      $display("FAIL async_setup: got %0d want 3", cycle);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (cycle !== 2'd0) begin
      miscompares++;
      $display("FAIL async_immediate: got %0d want 0", cycle);
    end
    stop = 1'b0;
    resetcount = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (cycle !== 2'd0) begin
        miscompares++;
        $display("FAIL async_held[%0d]: got %0d want 0", i, cycle);
      end
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (cycle !== 2'd1) begin
      miscompares++;
      $display("FAIL async_release: got %0d want 1", cycle);
    end
  endtask

  // Controller clears when the count reaches 2, giving a mod-3 sequence.
  task automatic test_feedback();
    logic [1:0] exp_seq [6];
    exp_seq = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    for (int i = 0; i < 6; i++) begin
      resetcount = (cycle == 2'd2);
      tick();
      vectors++;
      if (cycle !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL feedback[%0d]: got %0d want %0d", i, cycle, exp_seq[i]);
      end
    end
    resetcount = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    stop        = 1'b0;
    resetcount  = 1'b0;
    #1;
    vectors++;
    if (cycle !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_initial: got %0d want 0", cycle);
    end
    test_reset();
    test_free_run();
    test_sync_clear();
    test_hold();
    test_priority();
    test_async_reset();
    test_feedback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
